pyc_sync_mem_rd_stream: RTL and testbench



---
 rtl/pyc_sync_mem_rd_stream.sv | 106 ++++++++++
 tb/tb_pyc_sync_mem_rd_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pyc_sync_mem_rd_stream.sv
// pyc_sync_mem_rd_stream
// Read front-end for a synchronous 1R1W memory. It turns a valid/ready
// request stream into single-cycle read enables. The read data returns one
// cycle later and is queued with its tag in a small response FIFO.
// req_ready counts both queued entries and the read still in flight as used
// credits. A read is therefore only issued when a FIFO slot is already
// reserved for its data, and no response is ever dropped under backpressure.
module pyc_sync_mem_rd_stream #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [TAG_WIDTH-1:0]               req_tag,
    output logic                               mem_ren,
    output logic [ADDR_WIDTH-1:0]              mem_raddr,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [DATA_WIDTH-1:0]              resp_data,
    output logic [TAG_WIDTH-1:0]               resp_tag,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // The pointer wraps explicitly at the last slot, so any depth works,
    // not only a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic                  inflight_p1;
    logic [TAG_WIDTH-1:0]  inflight_tag_p1;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic [CNT_W-1:0]      occ;
    logic                  fire_p0;
    logic                  push_p1;
    logic                  pop;

    // ---- stage p0: request issue (registered credits only, no path from resp_ready)
    assign occ       = fifo_count + CNT_W'(inflight_p1);
    assign req_ready = (occ < DEPTH_CNT);
    assign fire_p0   = req_valid && req_ready && rst;
    assign mem_ren   = fire_p0;
    assign mem_raddr = req_addr;
    assign occupancy = occ;

    // ---- stage p1: memory data returns and is captured into the FIFO
    assign push_p1 = inflight_p1;

    // ---- response side: FIFO head
    assign resp_valid = (fifo_count != '0);
    assign resp_data  = fifo_data[rd_ptr];
    assign resp_tag   = fifo_tag[rd_ptr];
    assign pop        = resp_valid && resp_ready;

    // Control state: the in-flight flag, the FIFO pointers and the entry count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_p1 <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            inflight_p1 <= fire_p0;
            if (push_p1) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_p1, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Datapath: the tag travels with the read, then data and tag go into the FIFO slot.
    always_ff @(posedge clk) begin
        if (fire_p0) begin
            inflight_tag_p1 <= req_tag;
        end
        if (push_p1) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_tag[wr_ptr]  <= inflight_tag_p1;
        end
    end

endmodule

// File: tb/tb_pyc_sync_mem_rd_stream.sv
// Testbench for pyc_sync_mem_rd_stream: a behavioural memory, random and
// directed traffic, and a reference queue of outstanding reads. Every cycle
// the handshake signals, the occupancy and the head data are compared with it.
module tb_pyc_sync_mem_rd_stream;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [TW-1:0] req_tag;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic [OW-1:0] occupancy;

    pyc_sync_mem_rd_stream #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_tag(req_tag),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: registered read, holds stale data when ren is low.
    logic [DW-1:0] mem [64];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr[5:0]];
    end

    // Reference model: every accepted read that has not yet been consumed.
    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            cyc;
    } ent_t;
    ent_t q[$];
    int   cyc;

    int n_vec;
    int n_err;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // One clock: check at the negedge against the model, then advance the model at the posedge.
    task automatic step();
        logic exp_ready, exp_rv, fire, pop;
        ent_t e;
        @(negedge clk);
        exp_ready = (q.size() < DEPTH);
        // A read accepted in cycle N becomes visible at the head in cycle N+2.
        exp_rv    = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        fire      = req_valid && exp_ready && rst;
        pop       = exp_rv && resp_ready;
        if (rst) begin
            check_val("req_ready", 64'(req_ready), 64'(exp_ready));
            check_val("resp_valid", 64'(resp_valid), 64'(exp_rv));
            check_val("occupancy", 64'(occupancy), 64'(q.size()));
            check_val("occ_bound", 64'(occupancy <= OW'(DEPTH)), 64'(1));
            check_val("mem_ren", 64'(mem_ren), 64'(fire));
            if (fire) check_val("mem_raddr", mem_raddr, req_addr);
            if (exp_rv) begin
                check_val("resp_data", resp_data, q[0].data);
                check_val("resp_tag", 64'(resp_tag), 64'(q[0].tag));
            end
        end else begin
            check_val("mem_ren_in_rst", 64'(mem_ren), 64'(0));
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (fire) begin
                e.data = mem[req_addr[5:0]];
                e.tag  = req_tag;
                e.cyc  = cyc;
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_req();
        req_addr = {$urandom, $urandom};
        req_tag  = TW'($urandom);
    endtask

    initial begin
        int pv, pr;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        mem[5] = 64'h0000_0000_DEAD_BEEF;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Single read of address 5.
        req_addr  = 64'd5;
        req_tag   = 8'h11;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (4) step();

        // Eight back-to-back reads with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            req_addr  = 64'(i);
            req_tag   = 8'h20 + 8'(i);
            req_valid = 1'b1;
            step();
        end
        req_valid = 1'b0;
        repeat (4) step();

        // Backpressure: consumer stalled while requests are held for 10 cycles.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_req();
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (8) step();

        // Preload the FIFO, then stream with push and pop together so the pointers wrap.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            step();
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            rand_req();
            step();
        end
        req_valid = 1'b0;
        repeat (6) step();

        // Reset while one read is in flight and two entries are queued.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            step();
        end
        rst = 1'b0;
        step();
        rst       = 1'b1;
        req_valid = 1'b0;
        check_val("rst_occupancy", 64'(occupancy), 64'(0));
        check_val("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_val("rst_req_ready", 64'(req_ready), 64'(1));
        resp_ready = 1'b1;
        repeat (4) step();

        // Random traffic with the valid/ready densities changing every 500 cycles.
        pv = 50;
        pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pv = $urandom_range(100, 10);
                pr = $urandom_range(100, 5);
            end
            req_valid  = ($urandom_range(99, 0) < pv);
            resp_ready = ($urandom_range(99, 0) < pr);
            rand_req();
            step();
        end

        // Drain everything still outstanding.
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (2 * DEPTH + 4) step();
        check_val("drain_occupancy", 64'(occupancy), 64'(0));
        check_val("drain_model_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
